pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/hazard_unit.sv | 44 ++++
 rtl/pipe_control.sv | 166 ++++++++++++++++
 tb/tb_pipe_control.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared opcodes, ALU-op and forward-select encodings for pipe_control
package pipe_ctrl_pkg;

    localparam int OP_RTYPE = 0;
    localparam int OP_J     = 2;
    localparam int OP_BEQ   = 4;
    localparam int OP_ADDI  = 8;
    localparam int OP_LW    = 35;
    localparam int OP_SW    = 43;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - combinational load-use stall detection and EX operand forwarding select
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_dest,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_dest,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic exmem_live;
    logic memwb_live;

    // Register 0 is hardwired, so it never produces a hazard.
    assign exmem_live = exmem_reg_write && (exmem_dest != '0);
    assign memwb_live = memwb_reg_write && (memwb_dest != '0);

    assign stall = idex_mem_read && (idex_rt != '0) &&
                   ((idex_rt == id_rs) || (idex_rt == id_rt));

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (exmem_live && (exmem_dest == idex_rs))
            fwd_a = FWD_EXMEM;
        else if (memwb_live && (memwb_dest == idex_rs))
            fwd_a = FWD_MEMWB;
        if (exmem_live && (exmem_dest == idex_rt))
            fwd_b = FWD_EXMEM;
        else if (memwb_live && (memwb_dest == idex_rt))
            fwd_b = FWD_MEMWB;
    end

endmodule

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - 5-stage pipeline decode/control registers; PIPE_CTRL_JUMP_EN adds the j opcode and jump output
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_br_eq,
`ifdef PIPE_CTRL_JUMP_EN
    output logic              jump,
`endif
    output logic              stall,
    output logic              pc_src,
    output logic              if_flush,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic [1:0]        ex_alu_op,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_dest,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    ctrl_t             id_ctrl;
    logic              id_branch;
    logic              id_jump;
    logic              take;

    ctrl_t             idex_ctrl;
    logic [REG_AW-1:0] idex_rs;
    logic [REG_AW-1:0] idex_rt;
    logic [REG_AW-1:0] idex_rd;
    logic [REG_AW-1:0] ex_dest;

    logic              exmem_mem_read;
    logic              exmem_mem_write;
    logic              exmem_reg_write;
    logic              exmem_mem_to_reg;
    logic [REG_AW-1:0] exmem_dest;

    logic              memwb_reg_write;
    logic              memwb_mem_to_reg;
    logic [REG_AW-1:0] memwb_dest;

    always_comb begin
        id_ctrl   = '0;
        id_branch = 1'b0;
        id_jump   = 1'b0;
        if (id_valid) begin
            case (int'(id_op))
                OP_RTYPE: begin
                    id_ctrl.reg_dst   = 1'b1;
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_op    = ALU_FUNCT;
                end
                OP_LW: begin
                    id_ctrl.alu_src    = 1'b1;
                    id_ctrl.mem_read   = 1'b1;
                    id_ctrl.mem_to_reg = 1'b1;
                    id_ctrl.reg_write  = 1'b1;
                    id_ctrl.alu_op     = ALU_ADD;
                end
                OP_SW: begin
                    id_ctrl.alu_src   = 1'b1;
                    id_ctrl.mem_write = 1'b1;
                    id_ctrl.alu_op    = ALU_ADD;
                end
                OP_BEQ: begin
                    id_branch      = 1'b1;
                    id_ctrl.alu_op = ALU_SUB;
                end
                OP_ADDI: begin
                    id_ctrl.alu_src   = 1'b1;
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_op    = ALU_ADD;
                end
`ifdef PIPE_CTRL_JUMP_EN
                OP_J: id_jump = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .idex_mem_read   (idex_ctrl.mem_read),
        .idex_rs         (idex_rs),
        .idex_rt         (idex_rt),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .stall           (stall),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    // A stalled branch/jump is held in ID and re-evaluated next cycle.
    assign take     = !stall && ((id_branch && id_br_eq) || id_jump);
    assign pc_src   = take;
    assign if_flush = take;
`ifdef PIPE_CTRL_JUMP_EN
    assign jump     = !stall && id_jump;
`endif

    assign ex_dest = idex_ctrl.reg_dst ? idex_rd : idex_rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ctrl        <= '0;
            idex_rs          <= '0;
            idex_rt          <= '0;
            idex_rd          <= '0;
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_reg_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_dest       <= '0;
            memwb_reg_write  <= 1'b0;
            memwb_mem_to_reg <= 1'b0;
            memwb_dest       <= '0;
        end else begin
            if (stall) begin
                idex_ctrl <= '0;
                idex_rs   <= '0;
                idex_rt   <= '0;
                idex_rd   <= '0;
            end else begin
                idex_ctrl <= id_ctrl;
                idex_rs   <= id_rs;
                idex_rt   <= id_rt;
                idex_rd   <= id_rd;
            end
            exmem_mem_read   <= idex_ctrl.mem_read;
            exmem_mem_write  <= idex_ctrl.mem_write;
            exmem_reg_write  <= idex_ctrl.reg_write;
            exmem_mem_to_reg <= idex_ctrl.mem_to_reg;
            exmem_dest       <= ex_dest;
            memwb_reg_write  <= exmem_reg_write;
            memwb_mem_to_reg <= exmem_mem_to_reg;
            memwb_dest       <= exmem_dest;
        end
    end

    assign ex_reg_dst    = idex_ctrl.reg_dst;
    assign ex_alu_src    = idex_ctrl.alu_src;
    assign ex_alu_op     = idex_ctrl.alu_op;
    assign mem_read      = exmem_mem_read;
    assign mem_write     = exmem_mem_write;
    assign wb_reg_write  = memwb_reg_write;
    assign wb_mem_to_reg = memwb_mem_to_reg;
    assign wb_dest       = memwb_dest;

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - directed and random checks of pipe_control against an instruction-level pipeline model
module tb_pipe_control;

    localparam int REG_AW = 5;
    localparam int OP_W   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [OP_W-1:0]   id_op;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_br_eq;
    logic              stall, pc_src, if_flush;
    logic              ex_reg_dst, ex_alu_src;
    logic [1:0]        ex_alu_op;
    logic              mem_read, mem_write;
    logic              wb_reg_write, wb_mem_to_reg;
    logic [REG_AW-1:0] wb_dest;
    logic [1:0]        fwd_a, fwd_b;
`ifdef PIPE_CTRL_JUMP_EN
    logic              jump;
    localparam bit     JUMP_EN = 1'b1;
`else
    localparam bit     JUMP_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_control #(.REG_AW(REG_AW), .OP_W(OP_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_op         (id_op),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_br_eq      (id_br_eq),
`ifdef PIPE_CTRL_JUMP_EN
        .jump          (jump),
`endif
        .stall         (stall),
        .pc_src        (pc_src),
        .if_flush      (if_flush),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_alu_op     (ex_alu_op),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_dest       (wb_dest),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // One in-flight instruction as seen by later stages.
    typedef struct {
        logic       reg_dst, alu_src;
        logic [1:0] alu_op;
        logic       mem_read, mem_write, reg_write, mem_to_reg;
        logic [4:0] rs, rt, dest;
    } ent_t;

    ent_t pipe_q[$];     // [0] in EX, [1] in MEM, [2] in WB
    ent_t nop_e;
    logic model_stall;

    function automatic ent_t decode_model(logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        ent_t e = '{default: 0};
        e.rs = rs;
        e.rt = rt;
        if (v) begin
            case (op)
                6'd0:  begin e.reg_dst = 1; e.reg_write = 1; e.alu_op = 2'd2; end
                6'd35: begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; end
                6'd43: begin e.alu_src = 1; e.mem_write = 1; end
                6'd4:  e.alu_op = 2'd1;
                6'd8:  begin e.alu_src = 1; e.reg_write = 1; end
                default: ;
            endcase
        end
        e.dest = e.reg_dst ? rd : rt;
        return e;
    endfunction

    function automatic logic [1:0] fwd_model(logic [4:0] src, ent_t m, ent_t w);
        if (m.reg_write && m.dest != 0 && m.dest == src) return 2'b10;
        if (w.reg_write && w.dest != 0 && w.dest == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int op, input int rs, input int rt, input int rd,
                         input logic eq, input logic r);
        id_valid = v;
        id_op    = OP_W'(op);
        id_rs    = REG_AW'(rs);
        id_rt    = REG_AW'(rt);
        id_rd    = REG_AW'(rd);
        id_br_eq = eq;
        rst      = r;
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic settle();
        ent_t ex, mm, wb;
        logic taken;
        @(negedge clk);
        ex = pipe_q[0];
        mm = pipe_q[1];
        wb = pipe_q[2];
        model_stall = ex.mem_read && ex.rt != 0 && (ex.rt == id_rs || ex.rt == id_rt);
        taken = !model_stall && id_valid &&
                ((id_op == 6'd4 && id_br_eq) || (JUMP_EN && id_op == 6'd2));
        check("m_stall", stall, model_stall);
        check("m_pc_src", pc_src, taken);
        check("m_if_flush", if_flush, taken);
`ifdef PIPE_CTRL_JUMP_EN
        check("m_jump", jump, !model_stall && id_valid && id_op == 6'd2);
`endif
        check("m_ex_reg_dst", ex_reg_dst, ex.reg_dst);
        check("m_ex_alu_src", ex_alu_src, ex.alu_src);
        check("m_ex_alu_op", ex_alu_op, ex.alu_op);
        check("m_mem_read", mem_read, mm.mem_read);
        check("m_mem_write", mem_write, mm.mem_write);
        check("m_wb_reg_write", wb_reg_write, wb.reg_write);
        check("m_wb_mem_to_reg", wb_mem_to_reg, wb.mem_to_reg);
        check("m_wb_dest", wb_dest, wb.dest);
        check("m_fwd_a", fwd_a, fwd_model(ex.rs, mm, wb));
        check("m_fwd_b", fwd_b, fwd_model(ex.rt, mm, wb));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            pipe_q = '{nop_e, nop_e, nop_e};
        end else begin
            pipe_q.push_front(model_stall ? nop_e
                              : decode_model(id_valid, id_op, id_rs, id_rt, id_rd));
            void'(pipe_q.pop_back());
        end
        #1;
    endtask

    task automatic step(input logic v, input int op, input int rs, input int rt, input int rd,
                        input logic eq, input logic r);
        drive(v, op, rs, rt, rd, eq, r);
        settle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_pc_src"}, pc_src, 0);
        check({tag, "_if_flush"}, if_flush, 0);
        check({tag, "_ex"}, {ex_reg_dst, ex_alu_src, ex_alu_op}, 0);
        check({tag, "_mem"}, {mem_read, mem_write}, 0);
        check({tag, "_wb"}, {wb_reg_write, wb_mem_to_reg, wb_dest}, 0);
        check({tag, "_fwd"}, {fwd_a, fwd_b}, 0);
    endtask

    initial begin
        nop_e = '{default: 0};
        pipe_q = '{nop_e, nop_e, nop_e};
        model_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;

        // reset state
        step(0, 0, 0, 0, 0, 0, 0);
        check_all_zero("reset");
        advance();

        // lw r2 ; add r3,r2,r4 : one stall, bubble, then MEM/WB forward
        step(1, 35, 0, 2, 0, 0, 0);  advance();
        step(1, 0, 2, 4, 3, 0, 0);
        check("lu_stall", stall, 1);
        advance();
        step(1, 0, 2, 4, 3, 0, 0);
        check("lu_stall_once", stall, 0);
        check("lu_bubble", {ex_reg_dst, ex_alu_src, ex_alu_op}, 0);
        advance();
        step(0, 0, 0, 0, 0, 0, 0);
        check("lu_fwd_a", fwd_a, 2'b01);
        advance();

        // add r1 ; sub r5,r1,r1 : EX/MEM forward both operands
        step(1, 0, 2, 3, 1, 0, 0);   advance();
        step(1, 0, 1, 1, 5, 0, 0);
        check("exfwd_nostall", stall, 0);
        advance();
        step(0, 0, 0, 0, 0, 0, 0);
        check("exfwd_a", fwd_a, 2'b10);
        check("exfwd_b", fwd_b, 2'b10);
        advance();

        // beq taken / not taken
        step(1, 4, 1, 1, 0, 1, 0);
        check("beq_pc_src", pc_src, 1);
        check("beq_flush", if_flush, 1);
        advance();
        step(1, 4, 1, 2, 0, 0, 0);
        check("bne_pc_src", pc_src, 0);
        check("bne_flush", if_flush, 0);
        advance();

        // lw r0 followed by a consumer of r0
        step(1, 35, 1, 0, 0, 0, 0);  advance();
        step(1, 0, 0, 0, 6, 0, 0);
        check("r0_stall", stall, 0);
        advance();
        step(0, 0, 0, 0, 0, 0, 0);
        check("r0_fwd", {fwd_a, fwd_b}, 0);
        advance();

        // reset pulse during a load-use stall
        step(1, 35, 0, 2, 0, 0, 0);  advance();
        step(1, 0, 2, 4, 3, 0, 1);
        check("rst_pre_stall", stall, 1);
        advance();
        step(1, 0, 2, 4, 3, 0, 0);
        check_all_zero("rst_mid");
        advance();

        // j opcode
        step(1, 2, 0, 0, 0, 0, 0);
        check("j_pc_src", pc_src, JUMP_EN);
        check("j_flush", if_flush, JUMP_EN);
        advance();
        step(0, 0, 0, 0, 0, 0, 0);
        check("j_ex_ctrl", {ex_reg_dst, ex_alu_src, ex_alu_op}, 0);
        advance();

        // random traffic; a stalled instruction is held in ID like a real front end
        for (int i = 0; i < 400; i++) begin
            if (!model_stall || rst) begin
                int ops[7] = '{0, 35, 43, 4, 8, 2, 0};
                int op;
                ops[6] = int'($urandom_range(0, 63));
                op = ops[$urandom_range(0, 6)];
                drive($urandom_range(0, 7) != 0, op, $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
            end else begin
                rst = ($urandom_range(0, 39) == 0);
            end
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
